// File: rtl/uart_echo_tester.sv
// UART echo initiator: sends bytes SEED+i on txd (8N1) and checks each echo on rxd.
// Stop-and-wait: one byte in flight; the next start bit follows the CHECK cycle.
// No backpressure; a lost echo is closed out by TIMEOUT_CYCLES.
module uart_echo_tester #(
    parameter int         CLK_PER_HALF_BIT = 100,
    parameter int         NUM_BYTES        = 256,
    parameter logic [7:0] SEED             = 8'h00,
    parameter int         TIMEOUT_CYCLES   = 4000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    output logic        txd,
    input  logic        rxd,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [7:0]  last_bad_exp,
    output logic [7:0]  last_bad_got
);
    localparam int BW = $clog2(2 * CLK_PER_HALF_BIT);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(2 * CLK_PER_HALF_BIT - 1);
    localparam logic [BW-1:0] HALF_LAST = BW'(CLK_PER_HALF_BIT - 1);
    localparam logic [TW-1:0] TOUT      = TW'(TIMEOUT_CYCLES);
    localparam logic [15:0]   IDX_LAST  = 16'(NUM_BYTES - 1);

    typedef enum logic [2:0] {IDLE, SEND, WAIT, CHECK, DONE} state_t;
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rstate_t;

    state_t        state;
    logic [BW-1:0] tx_cnt;
    logic [3:0]    tx_bit;
    logic [15:0]   idx;
    logic [TW-1:0] tout_cnt;
    logic          cur_err;
    logic [7:0]    cur_got;

    rstate_t       rstate;
    logic          rx_s1, rx_s2, rx_s3;
    logic [BW-1:0] rcnt;
    logic [2:0]    rbit;
    logic [7:0]    rshift;
    logic          rx_done;
    logic [7:0]    rx_byte;
    logic          rx_ferr;

    logic [7:0]  exp_byte;
    logic [9:0]  tx_frame;
    logic        start_acc;
    logic        stray;
    logic        chk_err;
    logic [16:0] err_sum;
    logic [15:0] err_next;

    assign exp_byte  = SEED + idx[7:0];
    assign tx_frame  = {1'b1, exp_byte, 1'b0};
    assign start_acc = start && (state == IDLE || state == DONE);
    assign stray     = rx_done && (state != WAIT);
    assign chk_err   = (state == CHECK) && cur_err;
    assign err_sum   = {1'b0, err_count} + 17'(chk_err) + 17'(stray);
    assign err_next  = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    assign pass      = done && (err_count == 16'h0000);

    // Receiver: 2-flop sync, falling-edge arm, mid-bit sampling; always finishes a frame it began.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_s3   <= 1'b1;
            rstate  <= R_IDLE;
            rcnt    <= '0;
            rbit    <= '0;
            rshift  <= '0;
            rx_done <= 1'b0;
            rx_byte <= '0;
            rx_ferr <= 1'b0;
        end else begin
            rx_s1   <= rxd;
            rx_s2   <= rx_s1;
            rx_s3   <= rx_s2;
            rx_done <= 1'b0;
            case (rstate)
                R_IDLE: begin
                    if (rx_s3 && !rx_s2) begin
                        rcnt   <= '0;
                        rstate <= R_START;
                    end
                end
                R_START: begin
                    if (rcnt == HALF_LAST) begin
                        rcnt   <= '0;
                        rbit   <= '0;
                        rstate <= rx_s2 ? R_IDLE : R_DATA;
                    end else begin
                        rcnt <= rcnt + 1'b1;
                    end
                end
                R_DATA: begin
                    if (rcnt == BIT_LAST) begin
                        rcnt   <= '0;
                        rshift <= {rx_s2, rshift[7:1]};
                        rbit   <= rbit + 3'd1;
                        if (rbit == 3'd7) rstate <= R_STOP;
                    end else begin
                        rcnt <= rcnt + 1'b1;
                    end
                end
                R_STOP: begin
                    if (rcnt == BIT_LAST) begin
                        rcnt    <= '0;
                        rx_done <= 1'b1;
                        rx_byte <= rshift;
                        rx_ferr <= !rx_s2;
                        rstate  <= R_IDLE;
                    end else begin
                        rcnt <= rcnt + 1'b1;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= IDLE;
            txd          <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            tx_cnt       <= '0;
            tx_bit       <= '0;
            idx          <= '0;
            tout_cnt     <= '0;
            cur_err      <= 1'b0;
            cur_got      <= '0;
            err_count    <= '0;
            last_bad_exp <= '0;
            last_bad_got <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state  <= SEND;
                        txd    <= 1'b0;
                        busy   <= 1'b1;
                        done   <= 1'b0;
                        idx    <= '0;
                        tx_cnt <= '0;
                        tx_bit <= '0;
                    end
                end
                SEND: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_bit == 4'd9) begin
                            state    <= WAIT;
                            tout_cnt <= '0;
                            txd      <= 1'b1;
                        end else begin
                            tx_bit <= tx_bit + 4'd1;
                            txd    <= tx_frame[tx_bit + 4'd1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                WAIT: begin
                    // A completing frame outranks a timeout in the same cycle.
                    if (rx_done) begin
                        state   <= CHECK;
                        cur_err <= (rx_byte != exp_byte) || rx_ferr;
                        cur_got <= rx_byte;
                    end else if (tout_cnt == TOUT) begin
                        state   <= CHECK;
                        cur_err <= 1'b1;
                        cur_got <= 8'h00;
                    end else begin
                        tout_cnt <= tout_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    if (idx == IDX_LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        idx    <= idx + 16'd1;
                        state  <= SEND;
                        txd    <= 1'b0;
                        tx_cnt <= '0;
                        tx_bit <= '0;
                    end
                end
                default: state <= IDLE;
            endcase

            if (start_acc) begin
                err_count    <= '0;
                last_bad_exp <= '0;
                last_bad_got <= '0;
            end else if (stray) begin
                err_count    <= err_next;
                last_bad_exp <= 8'h00;
                last_bad_got <= rx_byte;
            end else if (chk_err) begin
                err_count    <= err_next;
                last_bad_exp <= exp_byte;
                last_bad_got <= cur_got;
            end
        end
    end
endmodule

// File: doc/uart_echo_tester.md
Name: uart_echo_tester

Overview:
- Initiator end of the UART echo path: drives a known byte sequence out on txd and checks each byte echoed back on rxd by the board's loopback responder.
- Stop-and-wait: one byte in flight; the next byte is sent only after the echo arrives or its timeout expires.
- Used for bring-up of the serial link and in self-checking benches; exposes pass/fail and error capture.
- Self-contained 8N1 serializer and deserializer; no dependency on other UART modules.

Parameters:
- CLK_PER_HALF_BIT, 100: clocks per half bit; bit period = 2*CLK_PER_HALF_BIT clocks.
- NUM_BYTES, 256: bytes per run, 1..65535.
- SEED, 8'h00: value of the first byte. Byte i = (SEED + i) mod 256.
- TIMEOUT_CYCLES, 4000: clocks allowed from the end of the transmitted stop bit to echo stop-bit sampling.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse that begins a run; accepted only in IDLE or DONE.
- txd  out  1  serial output, idle high.
- rxd  in  1  serial input, asynchronous to clk.
- busy  out  1  run in progress.
- done  out  1  run complete; held until the next start or reset.
- pass  out  1  high when done=1 and err_count=0.
- err_count  out  16  errors in the current run; saturates at 16'hFFFF.
- last_bad_exp  out  8  expected byte of the most recent error.
- last_bad_got  out  8  received byte of the most recent error; 8'h00 on timeout.

Behaviour:
- Reset (rstn=0 at posedge): state=IDLE, txd=1, busy=0, done=0, pass=0, err_count=0, last_bad_exp=0, last_bad_got=0. Reset has the same effect mid-run: transmission aborts immediately and txd=1 on the following cycle.
- Frame format: start bit 0, 8 data bits LSB first, stop bit 1. Each bit is held for exactly 2*CLK_PER_HALF_BIT clocks.
- States:
  - IDLE: waits for start.
  - SEND: serializer running.
  - WAIT: waits for the echo.
  - CHECK: one cycle.
  - DONE.
- start accepted in cycle N: err_count, captures and the index are cleared, done=0, busy=1. txd goes low starting at cycle N+1. start in SEND, WAIT or CHECK is ignored.
- SEND -> WAIT after the last stop-bit clock. The timeout counter starts at 0 on entering WAIT.
- RX path:
  - rxd passes through a 2-flop synchronizer.
  - A falling edge arms the receiver, which re-samples after CLK_PER_HALF_BIT clocks. If the re-sample is high, the edge was a glitch and the receiver re-arms.
  - Data bits and the stop bit are then sampled every 2*CLK_PER_HALF_BIT clocks, giving a mid-bit sample.
  - A stop bit sampled as 0 is a framing error.
- WAIT -> CHECK when a frame completes. The byte is in error if the received byte != expected byte or a framing error occurred.
- WAIT -> CHECK on timeout (counter reaches TIMEOUT_CYCLES); this is an error with got=8'h00. If a frame completes and the timeout expires in the same cycle, the frame takes priority.
- CHECK:
  - On error: err_count+1 (saturating), last_bad_exp and last_bad_got updated.
  - If index = NUM_BYTES-1: go to DONE (busy=0, done=1). Otherwise: index+1 and go to SEND; the next start bit begins on the following cycle.
- A frame completing outside WAIT (stray or late echo) counts as an error: exp=8'h00, got=the received byte. This does not change state.
- The receiver always completes a frame it has begun. A late echo that straddles a timeout is therefore counted as a stray byte.
- pass is combinational from done and err_count==0.

Test Plan:
- Bench setup: CLK_PER_HALF_BIT=4, NUM_BYTES=4, SEED=8'hA5, TIMEOUT_CYCLES=200.
- Direct loopback: txd wired to rxd through a 3-cycle delay; pulse start.
  - txd falls at N+1 and each bit lasts 8 clocks.
  - Bytes A5, A6, A7, A8 are sent.
  - Result: done=1, pass=1, err_count=0, busy=0.
- rxd held at 1: each byte times out.
  - Result: err_count=4, pass=0, last_bad_exp=A8, last_bad_got=00.
- Bench echo flips bit 0 of the third byte:
  - Result: err_count=1, last_bad_exp=A7, last_bad_got=A6, pass=0.
- Bench echoes the second byte with stop bit 0:
  - Result: err_count=1, last_bad_exp=A6, last_bad_got=A6.
- Reset mid-run: rstn=0 for one cycle during the data bits of byte 1.
  - Result: next cycle txd=1, busy=0, err_count=0. No further txd activity without start.
- start pulsed during SEND is ignored and the run proceeds unchanged.
  - start after DONE clears err_count and done and replays A5..A8.
  - A 2-clock low glitch on rxd in IDLE raises no error.
